pipeline_control: RTL and testbench
===================================

PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, number of cycles flush stays high per taken branch/jump (legal 1..7).
REQ-002 Parameter CNT_W, default 16, width of the stall performance counter.
REQ-003 clock  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 id_valid  input  1  decode stage holds a real instruction.
REQ-006 id_rs1, id_rs2  input  5 each  source register numbers of the decoding instruction.
REQ-007 id_rs1_used, id_rs2_used  input  1 each  the corresponding source is actually read.
REQ-008 id_rd  input  5  destination register; id_rd_we  input  1  instruction writes id_rd.
REQ-009 id_is_load  input  1  decoding instruction is a load (opcode 0000011).
REQ-010 ex_redirect  input  1  taken branch or jump resolved in EX this cycle.
REQ-011 stall  output  1  hold PC and IF/ID register this cycle.
REQ-012 flush  output  1  clear the decode output register (drives decode succ input).
REQ-013 bubble  output  1  insert NOP into ID/EX this cycle.
REQ-014 stall_count  output  CNT_W  saturating count of stall cycles since reset.

Function
REQ-015 Scoreboard SHALL hold two entries, EX and MEM, each {valid, rd, we, is_load}; every cycle MEM<=EX and EX<=decode instruction, or a cleared entry when stall, flush or !id_valid.
REQ-016 An entry SHALL match a source when valid, we, rd==source, source used, and rd!=0; register x0 never causes a hazard.
REQ-017 stall SHALL be combinational from current inputs and scoreboard, with zero-cycle latency.
REQ-018 bubble SHALL equal stall OR flush.
REQ-019 FSM states RUN, FLUSH; RUN->FLUSH on ex_redirect, FLUSH->RUN after FLUSH_CYCLES total flush cycles counted by a 3-bit down-counter.
REQ-020 flush SHALL be high combinationally in the cycle ex_redirect is sampled high in RUN, and throughout FLUSH, totalling exactly FLUSH_CYCLES cycles.
REQ-021 ex_redirect SHALL be ignored while in FLUSH.
REQ-022 Flush SHALL take priority over stall: stall forced low whenever flush is high.
REQ-023 Flush SHALL clear both scoreboard entries' valid bits at the next edge.
REQ-024 stall_count SHALL increment by one on each edge where stall is high and saturate at all-ones without wrapping.
REQ-025 Stall and ex_redirect in the same cycle: flush wins, stall low, stall_count unchanged.

Reset
REQ-026 While reset is low: FSM=RUN, flush counter=0, scoreboard valid bits=0, stall_count=0; stall=0, flush=0, bubble=0.
REQ-027 Reset asserted mid-flush or mid-stall SHALL abort immediately; first post-reset cycle behaves as RUN with empty scoreboard.

Configuration
REQ-028 Macro PIPELINE_CONTROL_FORWARD_EN defined: datapath has EX/MEM forwarding; stall only on a match against the EX entry with is_load set (one stall cycle per load-use).
REQ-029 Macro PIPELINE_CONTROL_FORWARD_EN undefined: stall on any match against EX or MEM entry (dependency on EX gives 2 stall cycles, on MEM gives 1); register file writes in first half-cycle so WB never hazards.

Verification
REQ-030 Forwarding on: lw x5 then add x6,x5,x1 back-to-back -> stall=1 for exactly 1 cycle, bubble=1, stall_count 0->1.
REQ-031 Forwarding off: addi x5 then add x6,x5,x1 -> stall=1 for 2 cycles; with one independent instruction between -> 1 cycle.
REQ-032 Any mode: writer rd=x0 followed by reader of x0 -> stall stays 0.
REQ-033 ex_redirect pulse 1 cycle, FLUSH_CYCLES=2 -> flush=1 for 2 cycles, second ex_redirect during flush ignored, stall=0 throughout.
REQ-034 Load-use hazard coincident with ex_redirect -> flush=1, stall=0, stall_count unchanged.
REQ-035 Reset pulled low during flush cycle 1 -> flush=0 immediately, stall_count=0; CNT_W=4 with 20 forced stalls -> stall_count holds 15.

Source files
------------

// File: rtl/pipeline_control_if.sv
// Decode/hazard handshake bundle between the pipeline and its hazard control.
// CNT_W sizes the stall performance counter carried back to the pipeline.
interface pipeline_control_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [4:0]       id_rd;
    logic             id_rd_we;
    logic             id_is_load;
    logic             ex_redirect;
    logic             stall;
    logic             flush;
    logic             bubble;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output id_rd, id_rd_we, id_is_load, ex_redirect,
        input  stall, flush, bubble, stall_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  id_rd, id_rd_we, id_is_load, ex_redirect,
        output stall, flush, bubble, stall_count
    );
endinterface

// File: rtl/pipeline_control.sv
// Hazard/flush control: EX/MEM scoreboard, redirect flush FSM, stall counter.
// Define PIPELINE_CONTROL_FORWARD_EN when the datapath forwards from EX/MEM.
module pipeline_control #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    pipeline_control_if.slave  bus
);
    typedef enum logic {RUN, FLUSH} state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } sb_t;

    localparam logic [2:0] LP_FC = 3'(FLUSH_CYCLES);

    state_t           r_state;
    state_t           w_state_nx;
    logic [2:0]       r_fcnt;
    logic [2:0]       w_fcnt_nx;
    sb_t              r_ex;
    sb_t              r_mem;
    sb_t              w_id;
    logic [CNT_W-1:0] r_cnt;
    logic             w_flush;
    logic             w_hz_ex;
    logic             w_hz_mem;
    logic             w_hz;
    logic             w_stall;
    logic             w_flush_o;

    function automatic logic f_match(
        input sb_t        e,
        input logic [4:0] src,
        input logic       used,
        input logic       need_ld
    );
        return e.valid & e.we & used & (e.rd == src)
             & (e.rd != 5'd0) & (e.ld | ~need_ld);
    endfunction

    always_comb begin
        w_state_nx = r_state;
        w_fcnt_nx  = r_fcnt;
        w_flush    = 1'b0;
        unique case (r_state)
            RUN: begin
                if (bus.ex_redirect) begin
                    w_flush = 1'b1;
                    if (LP_FC > 3'd1) begin
                        w_state_nx = FLUSH;
                        w_fcnt_nx  = LP_FC - 3'd1;
                    end
                end
            end
            FLUSH: begin
                w_flush   = 1'b1;
                w_fcnt_nx = r_fcnt - 3'd1;
                if (r_fcnt <= 3'd1) begin
                    w_state_nx = RUN;
                    w_fcnt_nx  = 3'd0;
                end
            end
            default: begin
                w_state_nx = RUN;
                w_fcnt_nx  = 3'd0;
            end
        endcase
    end

`ifdef PIPELINE_CONTROL_FORWARD_EN
    // Forwarding covers everything except a load still in EX.
    always_comb begin
        w_hz_ex  = f_match(r_ex, bus.id_rs1, bus.id_rs1_used, 1'b1)
                 | f_match(r_ex, bus.id_rs2, bus.id_rs2_used, 1'b1);
        w_hz_mem = 1'b0;
        w_hz     = w_hz_ex;
    end
`else
    always_comb begin
        w_hz_ex  = f_match(r_ex, bus.id_rs1, bus.id_rs1_used, 1'b0)
                 | f_match(r_ex, bus.id_rs2, bus.id_rs2_used, 1'b0);
        w_hz_mem = f_match(r_mem, bus.id_rs1, bus.id_rs1_used, 1'b0)
                 | f_match(r_mem, bus.id_rs2, bus.id_rs2_used, 1'b0);
        w_hz     = w_hz_ex | w_hz_mem;
    end
`endif

    // Outputs are held quiet while reset is asserted, whatever the inputs.
    assign w_flush_o       = i_rst_n & w_flush;
    assign w_stall         = i_rst_n & w_hz & ~w_flush;
    assign bus.flush       = w_flush_o;
    assign bus.stall       = w_stall;
    assign bus.bubble      = w_stall | w_flush_o;
    assign bus.stall_count = r_cnt;

    assign w_id = '{valid: 1'b1, rd: bus.id_rd,
                    we: bus.id_rd_we, ld: bus.id_is_load};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RUN;
            r_fcnt  <= 3'd0;
        end else begin
            r_state <= w_state_nx;
            r_fcnt  <= w_fcnt_nx;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ex  <= '0;
            r_mem <= '0;
        end else begin
            r_mem <= w_flush_o ? '0 : r_ex;
            if (w_stall || w_flush_o || !bus.id_valid)
                r_ex <= '0;
            else
                r_ex <= w_id;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (w_stall && (r_cnt != '1))
            r_cnt <= r_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control; a second instance with CNT_W=4
// shares the stimulus to exercise counter saturation.
module tb_pipeline_control;
`ifdef PIPELINE_CONTROL_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] id_rd;
    logic       id_rd_we;
    logic       id_is_load;
    logic       ex_redirect;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt = 0;

    pipeline_control_if #(.CNT_W(16)) ifa ();
    pipeline_control_if #(.CNT_W(4))  ifb ();

    assign ifa.id_valid    = id_valid;
    assign ifa.id_rs1      = id_rs1;
    assign ifa.id_rs2      = id_rs2;
    assign ifa.id_rs1_used = id_rs1_used;
    assign ifa.id_rs2_used = id_rs2_used;
    assign ifa.id_rd       = id_rd;
    assign ifa.id_rd_we    = id_rd_we;
    assign ifa.id_is_load  = id_is_load;
    assign ifa.ex_redirect = ex_redirect;
    assign ifb.id_valid    = id_valid;
    assign ifb.id_rs1      = id_rs1;
    assign ifb.id_rs2      = id_rs2;
    assign ifb.id_rs1_used = id_rs1_used;
    assign ifb.id_rs2_used = id_rs2_used;
    assign ifb.id_rd       = id_rd;
    assign ifb.id_rd_we    = id_rd_we;
    assign ifb.id_is_load  = id_is_load;
    assign ifb.ex_redirect = ex_redirect;

    pipeline_control #(.FLUSH_CYCLES(2), .CNT_W(16)) u_dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (ifa.slave)
    );

    pipeline_control #(.FLUSH_CYCLES(2), .CNT_W(4)) u_dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic inst(input logic v, input logic [4:0] rs1,
                        input logic u1, input logic [4:0] rs2,
                        input logic u2, input logic [4:0] rd,
                        input logic we, input logic ld);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs1_used = u1;
        id_rs2      = rs2;
        id_rs2_used = u2;
        id_rd       = rd;
        id_rd_we    = we;
        id_is_load  = ld;
    endtask

    task automatic nop();
        inst(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        ex_redirect = 1'b1;
        inst(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1);
        #3;
        chk("rst_stall", 32'(ifa.stall), 32'd0);
        chk("rst_flush", 32'(ifa.flush), 32'd0);
        chk("rst_bubble", 32'(ifa.bubble), 32'd0);
        chk("rst_cnt", 32'(ifa.stall_count), 32'd0);
        tick();
        rst_n = 1'b1;
        ex_redirect = 1'b0;
        nop();
        #1;
        chk("post_rst_flush", 32'(ifa.flush), 32'd0);
        chk("post_rst_stall", 32'(ifa.stall), 32'd0);
        tick();

        // load followed directly by a consumer
        inst(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        #1;
        chk("lw_stall", 32'(ifa.stall), 32'd0);
        tick();
        inst(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
        #1;
        chk("lu_stall1", 32'(ifa.stall), 32'd1);
        chk("lu_bubble1", 32'(ifa.bubble), 32'd1);
        chk("lu_cnt0", 32'(ifa.stall_count), 32'd0);
        tick();
        chk("lu_stall2", 32'(ifa.stall), FWD ? 32'd0 : 32'd1);
        chk("lu_cnt1", 32'(ifa.stall_count), 32'd1);
        tick();
        exp_cnt = FWD ? 1 : 2;
        chk("lu_done", 32'(ifa.stall), 32'd0);
        chk("lu_cnt2", 32'(ifa.stall_count), 32'(exp_cnt));
        nop();
        tick();
        tick();

        // ALU result consumed back to back
        inst(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
        tick();
        inst(1'b1, 5'd3, 1'b1, 5'd10, 1'b1, 5'd4, 1'b1, 1'b0);
        #1;
        chk("alu_b2b_1", 32'(ifa.stall), 32'd1 - 32'(FWD));
        tick();
        chk("alu_b2b_2", 32'(ifa.stall), 32'd1 - 32'(FWD));
        tick();
        chk("alu_b2b_3", 32'(ifa.stall), 32'd0);
        exp_cnt = exp_cnt + (FWD ? 0 : 2);
        chk("alu_b2b_cnt", 32'(ifa.stall_count), 32'(exp_cnt));
        nop();
        tick();
        tick();

        // one independent instruction in between
        inst(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        tick();
        inst(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0);
        #1;
        chk("gap_indep", 32'(ifa.stall), 32'd0);
        tick();
        inst(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        #1;
        chk("gap_stall", 32'(ifa.stall), 32'd1 - 32'(FWD));
        tick();
        chk("gap_done", 32'(ifa.stall), 32'd0);
        exp_cnt = exp_cnt + (FWD ? 0 : 1);
        chk("gap_cnt", 32'(ifa.stall_count), 32'(exp_cnt));
        nop();
        tick();
        tick();

        // x0 never hazards
        inst(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        inst(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd11, 1'b1, 1'b0);
        #1;
        chk("x0_ex", 32'(ifa.stall), 32'd0);
        tick();
        chk("x0_mem", 32'(ifa.stall), 32'd0);
        nop();
        tick();
        tick();

        // load-use coincident with redirect, repeat redirect in flush
        inst(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        tick();
        inst(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
        ex_redirect = 1'b1;
        #1;
        chk("fl1_flush", 32'(ifa.flush), 32'd1);
        chk("fl1_stall", 32'(ifa.stall), 32'd0);
        chk("fl1_bubble", 32'(ifa.bubble), 32'd1);
        tick();
        chk("fl2_flush", 32'(ifa.flush), 32'd1);
        chk("fl2_stall", 32'(ifa.stall), 32'd0);
        chk("fl2_cnt", 32'(ifa.stall_count), 32'(exp_cnt));
        tick();
        ex_redirect = 1'b0;
        #1;
        chk("fl3_flush", 32'(ifa.flush), 32'd0);
        chk("fl3_stall", 32'(ifa.stall), 32'd0);
        chk("fl3_bubble", 32'(ifa.bubble), 32'd0);
        chk("fl3_cnt", 32'(ifa.stall_count), 32'(exp_cnt));
        nop();
        tick();

        // reset in the middle of a flush
        ex_redirect = 1'b1;
        #1;
        chk("rf1_flush", 32'(ifa.flush), 32'd1);
        tick();
        ex_redirect = 1'b0;
        #1;
        chk("rf2_flush", 32'(ifa.flush), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rf_rst_flush", 32'(ifa.flush), 32'd0);
        chk("rf_rst_cnt_a", 32'(ifa.stall_count), 32'd0);
        chk("rf_rst_cnt_b", 32'(ifb.stall_count), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rf_run_flush", 32'(ifa.flush), 32'd0);
        tick();

        // repeated load-use pairs to saturate the narrow counter
        for (int i = 0; i < 20; i++) begin
            inst(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
            tick();
            inst(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
            tick();
            tick();
            tick();
            if (i == 0) begin
                chk("sat_first_a", 32'(ifa.stall_count),
                    FWD ? 32'd1 : 32'd2);
                chk("sat_first_b", 32'(ifb.stall_count),
                    FWD ? 32'd1 : 32'd2);
            end
        end
        chk("sat_wide", 32'(ifa.stall_count), FWD ? 32'd20 : 32'd40);
        chk("sat_narrow", 32'(ifb.stall_count), 32'd15);
        nop();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
